// File: rtl/prco_lmem_arb_pkg.sv
// prco_lmem_arb_pkg
// Shared definitions for the local-memory arbiter:
//   owner_t  - which requester owns the response cycle (NONE/LDR/DAT/FET)
//   state_t  - sequencer states (S_IDLE / S_BUSY)
//   GNT_*    - bit positions inside the one-hot grant vector {ldr, dat, fet}
//   gnt_to_owner - converts a one-hot grant into an owner code
package prco_lmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LDR  = 2'd1,
        OWN_DAT  = 2'd2,
        OWN_FET  = 2'd3
    } owner_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam int GNT_LDR = 2;
    localparam int GNT_DAT = 1;
    localparam int GNT_FET = 0;

    function automatic owner_t gnt_to_owner(input logic [2:0] gnt);
        if (gnt[GNT_LDR]) return OWN_LDR;
        if (gnt[GNT_DAT]) return OWN_DAT;
        if (gnt[GNT_FET]) return OWN_FET;
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/prco_lmem_arb_prio.sv
// prco_lmem_arb_prio
// Fixed-priority selector with fetch anti-starvation.
// Ports:
//   i_ldr_req, i_ldr_lock  loader request / burst lock
//   i_dat_req, i_fet_req   data-port and fetch requests
//   i_run_cnt              consecutive data grants made while fetch waited
//   q_gnt                  one-hot grant {ldr, dat, fet}, all zero when idle
module prco_lmem_arb_prio
    import prco_lmem_arb_pkg::*;
#(
    parameter int P_MAX_DATA_RUN = 4,
    parameter int P_CNT_W        = 3
) (
    input  logic               i_ldr_req,
    input  logic               i_ldr_lock,
    input  logic               i_dat_req,
    input  logic               i_fet_req,
    input  logic [P_CNT_W-1:0] i_run_cnt,
    output logic [2:0]         q_gnt
);

    logic w_fet_forced;

    // Once data has won P_MAX_DATA_RUN times in a row against a waiting
    // fetch, fetch takes the next slot.
    assign w_fet_forced = i_fet_req && (i_run_cnt == P_CNT_W'(P_MAX_DATA_RUN));

    always_comb begin
        q_gnt = 3'b000;
        if (i_ldr_req) begin
            q_gnt[GNT_LDR] = 1'b1;
        end else if (!i_ldr_lock) begin
            // The lock keeps the memory reserved even when the loader is idle.
            if (w_fet_forced) begin
                q_gnt[GNT_FET] = 1'b1;
            end else if (i_dat_req) begin
                q_gnt[GNT_DAT] = 1'b1;
            end else if (i_fet_req) begin
                q_gnt[GNT_FET] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prco_lmem_arb.sv
// prco_lmem_arb
// Arbiter/sequencer for the single-port local memory. Three requesters
// (loader, data port, fetch) share one access per cycle; the grant cycle
// drives the memory directly and the following cycle returns done/rdata.
// Ports:
//   i_clk, i_reset                clock, asynchronous active-low reset
//   i_ldr_* / q_ldr_*             loader write port (req, lock, addr, wdata, ack, done)
//   i_dat_* / q_dat_*             LW/SW port (req, we, addr, wdata, ack, done, rdata)
//   i_fet_* / q_fet_*             instruction fetch (req, addr, ack, done, rdata)
//   q_mem_en/we/addr/dina         memory strobes, valid in the grant cycle
//   i_mem_douta                   memory read data, one cycle after the strobe
//   q_err                         pulse with done for an out-of-range access
module prco_lmem_arb
    import prco_lmem_arb_pkg::*;
#(
    parameter int P_ADDR_W       = 16,
    parameter int P_DATA_W       = 16,
    parameter int P_LMEM_DEPTH   = 256,
    parameter int P_MAX_DATA_RUN = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_ldr_req,
    input  logic                i_ldr_lock,
    input  logic [P_ADDR_W-1:0] i_ldr_addr,
    input  logic [P_DATA_W-1:0] i_ldr_wdata,
    output logic                q_ldr_ack,
    output logic                q_ldr_done,
    input  logic                i_dat_req,
    input  logic                i_dat_we,
    input  logic [P_ADDR_W-1:0] i_dat_addr,
    input  logic [P_DATA_W-1:0] i_dat_wdata,
    output logic                q_dat_ack,
    output logic                q_dat_done,
    output logic [P_DATA_W-1:0] q_dat_rdata,
    input  logic                i_fet_req,
    input  logic [P_ADDR_W-1:0] i_fet_addr,
    output logic                q_fet_ack,
    output logic                q_fet_done,
    output logic [P_DATA_W-1:0] q_fet_rdata,
    output logic                q_mem_en,
    output logic                q_mem_we,
    output logic [P_ADDR_W-1:0] q_mem_addr,
    output logic [P_DATA_W-1:0] q_mem_dina,
    input  logic [P_DATA_W-1:0] i_mem_douta,
    output logic                q_err
);

    localparam int                LP_CNT_W = $clog2(P_MAX_DATA_RUN + 1);
    localparam logic [P_ADDR_W:0] LP_DEPTH = (P_ADDR_W + 1)'(P_LMEM_DEPTH);

    state_t                r_state, w_state_next;
    owner_t                r_owner;
    logic                  r_oor;
    logic                  r_rd;
    logic [LP_CNT_W-1:0]   r_run_cnt;
    logic [P_DATA_W-1:0]   r_dat_rdata;
    logic [P_DATA_W-1:0]   r_fet_rdata;

    logic [2:0]            w_gnt_raw;
    logic [2:0]            w_gnt;
    logic                  w_any_gnt;
    logic [P_ADDR_W-1:0]   w_sel_addr;
    logic [P_DATA_W-1:0]   w_sel_wdata;
    logic                  w_sel_we;
    logic                  w_in_range;
    logic                  w_busy;
    logic                  w_dat_rd_resp;
    logic                  w_fet_resp;

    prco_lmem_arb_prio #(
        .P_MAX_DATA_RUN (P_MAX_DATA_RUN),
        .P_CNT_W        (LP_CNT_W)
    ) u_prio (
        .i_ldr_req  (i_ldr_req),
        .i_ldr_lock (i_ldr_lock),
        .i_dat_req  (i_dat_req),
        .i_fet_req  (i_fet_req),
        .i_run_cnt  (r_run_cnt),
        .q_gnt      (w_gnt_raw)
    );

    // No grant while reset is held, so every output reads 0 immediately.
    assign w_gnt     = i_reset ? w_gnt_raw : 3'b000;
    assign w_any_gnt = |w_gnt;

    assign q_ldr_ack = w_gnt[GNT_LDR];
    assign q_dat_ack = w_gnt[GNT_DAT];
    assign q_fet_ack = w_gnt[GNT_FET];

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        if (w_gnt[GNT_LDR]) begin
            w_sel_addr  = i_ldr_addr;
            w_sel_wdata = i_ldr_wdata;
            w_sel_we    = 1'b1;
        end else if (w_gnt[GNT_DAT]) begin
            w_sel_addr  = i_dat_addr;
            w_sel_wdata = i_dat_wdata;
            w_sel_we    = i_dat_we;
        end else if (w_gnt[GNT_FET]) begin
            w_sel_addr  = i_fet_addr;
        end
    end

    assign w_in_range = {1'b0, w_sel_addr} < LP_DEPTH;

    // Out-of-range grants are acked but never reach the memory.
    assign q_mem_en   = w_any_gnt && w_in_range;
    assign q_mem_we   = q_mem_en && w_sel_we;
    assign q_mem_addr = q_mem_en ? w_sel_addr : '0;
    assign q_mem_dina = q_mem_we ? w_sel_wdata : '0;

    always_comb begin
        w_state_next = S_IDLE;
        if (w_any_gnt) begin
            w_state_next = S_BUSY;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_owner <= OWN_NONE;
            r_oor   <= 1'b0;
            r_rd    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_owner <= gnt_to_owner(w_gnt);
            r_oor   <= w_any_gnt && !w_in_range;
            r_rd    <= w_gnt[GNT_FET] || (w_gnt[GNT_DAT] && !i_dat_we);
        end
    end

    // Counts data wins against a waiting fetch; any fetch grant or a cycle
    // without a fetch request restarts the run.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_run_cnt <= '0;
        end else if (!i_fet_req || w_gnt[GNT_FET]) begin
            r_run_cnt <= '0;
        end else if (w_gnt[GNT_DAT]) begin
            r_run_cnt <= r_run_cnt + LP_CNT_W'(1);
        end
    end

    assign w_busy        = (r_state == S_BUSY);
    assign q_ldr_done    = w_busy && (r_owner == OWN_LDR);
    assign q_dat_done    = w_busy && (r_owner == OWN_DAT);
    assign q_fet_done    = w_busy && (r_owner == OWN_FET);
    assign q_err         = w_busy && r_oor;
    assign w_dat_rd_resp = q_dat_done && r_rd;
    assign w_fet_resp    = q_fet_done;

    // Read data passes straight through in the response cycle and is then
    // held so the requester may sample it late.
    assign q_dat_rdata = w_dat_rd_resp ? (r_oor ? '0 : i_mem_douta) : r_dat_rdata;
    assign q_fet_rdata = w_fet_resp    ? (r_oor ? '0 : i_mem_douta) : r_fet_rdata;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_dat_rdata <= '0;
            r_fet_rdata <= '0;
        end else begin
            r_dat_rdata <= q_dat_rdata;
            r_fet_rdata <= q_fet_rdata;
        end
    end

endmodule
